seg_scan_controller: RTL and testbench

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_scan_controller_pkg.sv | 14 +
 rtl/seg_scan_controller_decoder.sv | 30 +++
 rtl/seg_scan_controller.sv | 138 +++++++++++++
 tb/tb_seg_scan_controller.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seg_scan_controller_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  // Anode drive level for an unselected digit; replicated to NUM_DIGITS.
  localparam logic       AN_OFF_BIT = 1'b1;

endpackage

// File: rtl/seg_scan_controller_decoder.sv
// Hex nibble to active-low seven-segment pattern, bit order g..a.
module hexSevenSegmentDecoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed hex display scanner: guard-blanked digit slots, frame-latched
// inputs so a frame never tears, optional leading-zero suppression.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    blank_lz,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (REFRESH_DIV > GUARD) ? REFRESH_DIV : GUARD;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      GUARD_LAST   = CNT_W'(GUARD - 1);
  localparam logic [CNT_W-1:0]      DRIVE_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      DRIVE_PENULT = CNT_W'(REFRESH_DIV - 2);
  localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF       = {NUM_DIGITS{AN_OFF_BIT}};

  scan_state_t             state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [4*NUM_DIGITS-1:0] value_lat_reg;
  logic [NUM_DIGITS-1:0]   dp_lat_reg;
  logic                    lz_lat_reg;
  logic [7:0]              seg_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic                    frame_done_reg;

  logic [3:0]            nibble_sel;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  suppress;
  logic [7:0]            digit_pattern;
  logic [NUM_DIGITS-1:0] an_sel;

  // zero_from[i]: every latched nibble from digit i up to the top is zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero_from
    assign zero_from[gi] = (value_lat_reg[4*NUM_DIGITS-1:4*gi] == '0);
  end

  assign nibble_sel = value_lat_reg[{idx_reg, 2'b00} +: 4];

  hexSevenSegmentDecoder u_dec (
    .hex (nibble_sel),
    .seg (dec_seg)
  );

  assign suppress      = lz_lat_reg && (idx_reg != '0) && zero_from[idx_reg];
  assign digit_pattern = {~dp_lat_reg[idx_reg], suppress ? 7'h7F : dec_seg};
  assign an_sel        = ~(NUM_DIGITS'(1) << idx_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      value_lat_reg  <= '0;
      dp_lat_reg     <= '0;
      lz_lat_reg     <= 1'b0;
      seg_reg        <= SEG_BLANK;
      an_reg         <= AN_OFF;
      frame_done_reg <= 1'b0;
    end else if (!enable) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      seg_reg        <= SEG_BLANK;
      an_reg         <= AN_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          state_reg     <= ST_BLANK;
          idx_reg       <= '0;
          cnt_reg       <= '0;
          value_lat_reg <= value;
          dp_lat_reg    <= dp_en;
          lz_lat_reg    <= blank_lz;
          seg_reg       <= SEG_BLANK;
          an_reg        <= AN_OFF;
        end
        ST_BLANK: begin
          if (cnt_reg == GUARD_LAST) begin
            state_reg <= ST_DRIVE;
            cnt_reg   <= '0;
            an_reg    <= an_sel;
            seg_reg   <= digit_pattern;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DRIVE: begin
          // Registered pulse lands on the final cycle of the last digit slot.
          frame_done_reg <= (idx_reg == IDX_LAST) && (cnt_reg == DRIVE_PENULT);
          if (cnt_reg == DRIVE_LAST) begin
            state_reg <= ST_BLANK;
            cnt_reg   <= '0;
            an_reg    <= AN_OFF;
            seg_reg   <= SEG_BLANK;
            if (idx_reg == IDX_LAST) begin
              idx_reg       <= '0;
              value_lat_reg <= value;
              dp_lat_reg    <= dp_en;
              lz_lat_reg    <= blank_lz;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          seg_reg   <= SEG_BLANK;
          an_reg    <= AN_OFF;
        end
      endcase
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench: table of single-frame scans plus tearing, abort and reset sequences.
module tb_seg_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] exp;   // expected seg per digit, digit 0 in the low byte
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  seg_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .value      (value),
    .dp_en      (dp_en),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  task automatic check(input string name, input logic [3:0] ea, input logic [7:0] es, input logic ef);
    checks++;
    if (an !== ea || seg !== es || frame_done !== ef) begin
      failures++;
      $display("FAIL %s: got an=%b seg=%h fd=%b, want an=%b seg=%h fd=%b",
               name, an, seg, frame_done, ea, es, ef);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks cycles 1..ncyc of a frame; cycle 1 is the first guard cycle.
  task automatic run_frame(input string name, input logic [31:0] exp, input int ncyc,
                           input int chg_at, input logic [15:0] chg_val);
    logic [3:0] ea;
    logic [7:0] es;
    int d, k;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == chg_at) value = chg_val;
      tick();
      d  = (c - 1) / 5;
      k  = (c - 1) % 5;
      ea = 4'hF;
      es = 8'hFF;
      if (k != 0) begin
        ea[d] = 1'b0;
        es    = exp[8*d +: 8];
      end
      check($sformatf("%s c%0d", name, c), ea, es, c == 20);
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, 4'hF, 8'hFF, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4B099};
    vecs[1] = '{16'h000A, 4'b0000, 1'b1, 32'hFFFFFF88};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
    vecs[3] = '{16'h8888, 4'b0100, 1'b0, 32'h80008080};
    vecs[4] = '{16'h0F05, 4'b0000, 1'b1, 32'hFF8EC092};
    vecs[5] = '{16'h0001, 4'b1000, 1'b1, 32'h7FFFFFF9};
    vecs[6] = '{16'h1234, 4'b0000, 1'b1, 32'hF9A4B099};
    vecs[7] = '{16'h5678, 4'b0001, 1'b0, 32'h9282F800};

    rst = 1'b1; enable = 1'b1; value = 16'h0; dp_en = 4'h0; blank_lz = 1'b0;
    @(negedge clk);
    idle_cycles("reset", 3);
    rst = 1'b0;
    $display("reset sequence done");

    for (int v = 0; v < 8; v++) begin
      enable = 1'b0;
      idle_cycles("pre_idle", 2);
      value = vecs[v].value; dp_en = vecs[v].dp; blank_lz = vecs[v].lz;
      enable = 1'b1;
      run_frame($sformatf("vec%0d", v), vecs[v].exp, 20, 0, 16'h0);
      $display("vector %0d value=%h dp=%b lz=%b scanned", v, vecs[v].value, vecs[v].dp, vecs[v].lz);
    end

    // Tearing: the frame in flight keeps the old value, the next one picks up ABCD.
    enable = 1'b0;
    idle_cycles("tear_idle", 2);
    value = 16'h1234; dp_en = 4'h0; blank_lz = 1'b0;
    enable = 1'b1;
    run_frame("tear_f1", 32'hF9A4B099, 20, 7, 16'hABCD);
    run_frame("tear_f2", 32'h8883C6A1, 20, 0, 16'h0);
    $display("tearing sequence done");

    // Abort mid digit 2, then re-enable.
    enable = 1'b0;
    idle_cycles("abort_idle", 2);
    value = 16'h1234;
    enable = 1'b1;
    run_frame("abort_pre", 32'hF9A4B099, 13, 0, 16'h0);
    enable = 1'b0;
    idle_cycles("abort", 3);
    enable = 1'b1;
    run_frame("abort_re", 32'hF9A4B099, 20, 0, 16'h0);
    $display("abort sequence done");

    // Reset mid-DRIVE with enable held high.
    run_frame("rst_pre", 32'hF9A4B099, 8, 0, 16'h0);
    rst = 1'b1;
    idle_cycles("rst_mid", 2);
    rst = 1'b0;
    value = 16'hABCD;
    run_frame("rst_post", 32'h8883C6A1, 20, 0, 16'h0);
    $display("mid-drive reset sequence done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
